// File: rtl/button_gesture_decoder.sv
// Push-button front end: synchronise, debounce, and classify each gesture as
// single press, double press or hold, emitting a one-cycle 2-bit opcode.
module button_gesture_decoder #(
    parameter int DEBOUNCE_CYC = 4,
    parameter int HOLD_CYC     = 16,
    parameter int GAP_CYC      = 8,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    output logic [1:0] select,
    output logic       sel_valid,
    output logic       btn_db
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRESS1   = 3'd1,
        WAIT_GAP = 3'd2,
        PRESS2   = 3'd3,
        WAIT_REL = 3'd4
    } state_t;

    localparam logic [1:0] OP_NP = 2'b00;
    localparam logic [1:0] OP_S  = 2'b01;
    localparam logic [1:0] OP_D  = 2'b10;
    localparam logic [1:0] OP_H  = 2'b11;

    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] dcnt;
    logic [CNT_W-1:0] tmr;
    state_t           state;
    state_t           state_nxt;
    logic [1:0]       sel_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
        end
    end

    // dcnt only runs while the synchronised level disagrees with btn_db
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dcnt   <= '0;
            btn_db <= 1'b0;
        end else if (s2 == btn_db) begin
            dcnt <= '0;
        end else if (dcnt == DB_LAST) begin
            dcnt   <= '0;
            btn_db <= s2;
        end else begin
            dcnt <= dcnt + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            tmr       <= '0;
            select    <= OP_NP;
            sel_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            select    <= sel_nxt;
            sel_valid <= (sel_nxt != OP_NP);
            if (state_nxt != state) begin
                tmr <= '0;
            end else if (tmr != '1) begin
                tmr <= tmr + ONE;
            end
        end
    end

    // Button edges are tested before timer expiry so release/press win ties
    always_comb begin
        state_nxt = state;
        sel_nxt   = OP_NP;
        case (state)
            IDLE: begin
                if (btn_db) state_nxt = PRESS1;
            end
            PRESS1: begin
                if (!btn_db) begin
                    state_nxt = WAIT_GAP;
                end else if (tmr == HOLD_LAST) begin
                    state_nxt = WAIT_REL;
                    sel_nxt   = OP_H;
                end
            end
            WAIT_GAP: begin
                if (btn_db) begin
                    state_nxt = PRESS2;
                end else if (tmr == GAP_LAST) begin
                    state_nxt = IDLE;
                    sel_nxt   = OP_S;
                end
            end
            PRESS2: begin
                if (!btn_db) begin
                    state_nxt = IDLE;
                    sel_nxt   = OP_D;
                end else if (tmr == HOLD_LAST) begin
                    state_nxt = WAIT_REL;
                    sel_nxt   = OP_D;
                end
            end
            WAIT_REL: begin
                if (!btn_db) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_button_gesture_decoder.sv
// Directed bench for button_gesture_decoder: a negedge monitor tallies opcode
// pulses and protocol faults, and each scenario checks the tally deltas.
module tb_button_gesture_decoder;

    logic       clk;
    logic       rst;
    logic       btn_raw;
    logic [1:0] select;
    logic       sel_valid;
    logic       btn_db;

    int checks = 0;
    int errors = 0;

    int n_s = 0;
    int n_d = 0;
    int n_h = 0;
    int n_bad = 0;
    int n_db_hi = 0;
    logic prev_valid = 1'b0;

    int base_s, base_d, base_h, base_bad, base_db;

    button_gesture_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .select    (select),
        .sel_valid (sel_valid),
        .btn_db    (btn_db)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse tally; a valid/select disagreement or back-to-back pulse is a fault
    always @(negedge clk) begin
        if (sel_valid) begin
            case (select)
                2'b01: n_s++;
                2'b10: n_d++;
                2'b11: n_h++;
                default: n_bad++;
            endcase
        end else if (select != 2'b00) begin
            n_bad++;
        end
        if (sel_valid && prev_valid) n_bad++;
        prev_valid = sel_valid;
        if (btn_db) n_db_hi++;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input int n);
        btn_raw = 1'b1;
        cycles(n);
        btn_raw = 1'b0;
    endtask

    task automatic mark();
        base_s   = n_s;
        base_d   = n_d;
        base_h   = n_h;
        base_bad = n_bad;
        base_db  = n_db_hi;
    endtask

    task automatic expect_pulses(input string tag, input int es, input int ed, input int eh);
        check({tag, "_s"},   n_s - base_s, es);
        check({tag, "_d"},   n_d - base_d, ed);
        check({tag, "_h"},   n_h - base_h, eh);
        check({tag, "_bad"}, n_bad - base_bad, 0);
    endtask

    initial begin
        int lat;
        rst     = 1'b0;
        btn_raw = 1'b0;

        // 1: reset state
        mark();
        @(negedge clk);
        check("rst_select", int'(select), 0);
        check("rst_valid", int'(sel_valid), 0);
        check("rst_db", int'(btn_db), 0);
        cycles(3);
        rst = 1'b1;
        cycles(10);
        expect_pulses("idle", 0, 0, 0);
        check("idle_db", n_db_hi - base_db, 0);

        // 2: single press, with debounce latency measured at btn_db
        mark();
        btn_raw = 1'b1;
        lat = 0;
        for (int k = 1; k <= 6; k++) begin
            cycles(1);
            if (lat == 0 && btn_db) lat = k;
        end
        btn_raw = 1'b0;
        check("db_latency", lat, 6);
        cycles(30);
        expect_pulses("single", 1, 0, 0);

        // 3: double press
        mark();
        press(6);
        cycles(5);
        press(6);
        cycles(30);
        expect_pulses("double", 0, 1, 0);

        // 4: hold, opcode appears before release and nothing follows
        mark();
        press(30);
        check("hold_before_rel", n_h - base_h, 1);
        cycles(30);
        expect_pulses("hold", 0, 0, 1);

        // 5: glitch shorter than the debounce window
        mark();
        press(2);
        cycles(20);
        check("glitch_db", n_db_hi - base_db, 0);
        expect_pulses("glitch", 0, 0, 0);

        // 6: reset mid-press; the tail left after reset is too short to debounce
        mark();
        btn_raw = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 7) rst = 1'b0;
            if (i == 8) rst = 1'b1;
            cycles(1);
            if (i == 7) check("midrst_db", int'(btn_db), 0);
        end
        btn_raw = 1'b0;
        cycles(30);
        expect_pulses("midrst", 0, 0, 0);

        // 7: a third press after a double is a fresh single
        mark();
        press(6);
        cycles(5);
        press(6);
        cycles(5);
        press(6);
        cycles(30);
        expect_pulses("triple", 1, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
